// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the fetch entry carried from the
// memory return path through the prefetch FIFO to decode.
package cpu_pkg;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned INST_W = 16;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO for fetch_queue. Synchronous, power-of-two depth. Clear has
// priority over push and pop.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear_i      drop every entry this cycle
//   push_i       write push_data_i at the tail
//   push_data_i  entry to write
//   pop_i        retire the head entry (caller guarantees count_o != 0)
//   head_o       entry at the head (undefined while empty)
//   count_o      number of stored entries
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CntW-1:0] count_o
);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; count_q qualifies every read.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Fetch credit must keep the FIFO from ever being full at a push.
    always_ff @(posedge clk) begin
        if (!reset && !clear_i) begin
            assert (!(push_i && (32'(count_q) == DEPTH)))
                else $error("fetch_fifo overflow");
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, drives the fixed-latency memory read
// port, tracks requests in flight and buffers returned words for decode.
// Optional macro FETCH_QUEUE_STATS_EN adds saturating statistics counters.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   imem_raddr        word address (pc[15:1]) to the memory
//   imem_rdata        instruction word, MEM_LAT cycles after its address
//   out_valid/ready   handshake to decode; out_inst/out_pc are the FIFO head
//   redirect          flush-and-restart at redirect_pc (bit 0 ignored)
//   halt              stop issuing new fetches
//   stat_fetched      (stats build) pushes into the FIFO
//   stat_killed       (stats build) in-flight plus buffered entries dropped by redirect
//   stat_stall        (stats build) cycles with out_valid && !out_ready
module fetch_queue
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter int unsigned     MEM_LAT  = 2,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PC_W-2:0]   imem_raddr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_killed,
    output logic [31:0]       stat_stall
`endif
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned InfW = $clog2(MEM_LAT + 1);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [MEM_LAT-1:0] fl_valid_q;
    logic [PC_W-1:0]    fl_pc_q [MEM_LAT];
    logic [InfW-1:0]    inflight;
    logic [CntW-1:0]    count;
    logic               issue, push, pop, clear;
    fetch_entry_t       head, push_data;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) inflight = inflight + InfW'(fl_valid_q[i]);
    end

    // Credit ignores a same-cycle pop so the FIFO can never overflow.
    assign issue = !reset && !redirect && !halt &&
                   ((32'(count) + 32'(inflight)) < DEPTH);

    always_comb begin
        pc_d = pc_q;
        if (redirect)   pc_d = {redirect_pc[PC_W-1:1], 1'b0};
        else if (issue) pc_d = pc_q + PC_W'(2);
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            fl_valid_q <= '0;
        end else begin
            fl_valid_q[0] <= issue;
            for (int i = 1; i < MEM_LAT; i++) fl_valid_q[i] <= fl_valid_q[i-1];
        end
        fl_pc_q[0] <= pc_q;
        for (int i = 1; i < MEM_LAT; i++) fl_pc_q[i] <= fl_pc_q[i-1];
    end

    assign imem_raddr = pc_q[PC_W-1:1];

    // Data for requests killed by redirect is dropped because the valids are cleared.
    assign push           = fl_valid_q[MEM_LAT-1] && !redirect;
    assign push_data.inst = imem_rdata;
    assign push_data.pc   = fl_pc_q[MEM_LAT-1];
    assign pop            = out_valid && out_ready && !redirect;
    assign clear          = redirect;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign out_valid = (count != '0);
    assign out_inst  = out_valid ? head.inst : '0;
    assign out_pc    = out_valid ? head.pc   : '0;

`ifdef FETCH_QUEUE_STATS_EN
    logic [32:0] kill_sum;
    assign kill_sum = {1'b0, stat_killed} + 33'(inflight) + 33'(count);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched <= '0;
            stat_killed  <= '0;
            stat_stall   <= '0;
        end else begin
            if (push && (stat_fetched != '1)) stat_fetched <= stat_fetched + 32'd1;
            if (redirect) stat_killed <= kill_sum[32] ? '1 : kill_sum[31:0];
            if (out_valid && !out_ready && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int unsigned MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset, out_ready, redirect, halt;
    logic [15:0] redirect_pc;

    // a: default build, w: RESET_PC wrap, d: DEPTH 8
    logic [14:0] raddr_a, raddr_w, raddr_d;
    logic [15:0] rdata_a, rdata_w, rdata_d;
    logic        valid_a, valid_w, valid_d;
    logic [15:0] inst_a, inst_w, inst_d, pc_a, pc_w, pc_d;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] sf_a, sk_a, ss_a, sf_w, sk_w, ss_w, sf_d, sk_d, ss_d;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory model: word N returns 16'h8000 + N, MEM_LAT cycles after the address.
    logic [14:0] ap_a [MEM_LAT];
    logic [14:0] ap_w [MEM_LAT];
    logic [14:0] ap_d [MEM_LAT];
    always @(posedge clk) begin
        ap_a[0] <= raddr_a;
        ap_w[0] <= raddr_w;
        ap_d[0] <= raddr_d;
        for (int i = 1; i < MEM_LAT; i++) begin
            ap_a[i] <= ap_a[i-1];
            ap_w[i] <= ap_w[i-1];
            ap_d[i] <= ap_d[i-1];
        end
    end
    assign rdata_a = 16'h8000 + {1'b0, ap_a[MEM_LAT-1]};
    assign rdata_w = 16'h8000 + {1'b0, ap_w[MEM_LAT-1]};
    assign rdata_d = 16'h8000 + {1'b0, ap_d[MEM_LAT-1]};

    fetch_queue #(.RESET_PC(16'h0000), .MEM_LAT(MEM_LAT), .DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .imem_raddr(raddr_a), .imem_rdata(rdata_a),
        .out_valid(valid_a), .out_ready(out_ready), .out_inst(inst_a), .out_pc(pc_a),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
`ifdef FETCH_QUEUE_STATS_EN
        , .stat_fetched(sf_a), .stat_killed(sk_a), .stat_stall(ss_a)
`endif
    );

    fetch_queue #(.RESET_PC(16'hFFFC), .MEM_LAT(MEM_LAT), .DEPTH(4)) dut_w (
        .clk(clk), .reset(reset), .imem_raddr(raddr_w), .imem_rdata(rdata_w),
        .out_valid(valid_w), .out_ready(out_ready), .out_inst(inst_w), .out_pc(pc_w),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
`ifdef FETCH_QUEUE_STATS_EN
        , .stat_fetched(sf_w), .stat_killed(sk_w), .stat_stall(ss_w)
`endif
    );

    fetch_queue #(.RESET_PC(16'h0000), .MEM_LAT(MEM_LAT), .DEPTH(8)) dut_d (
        .clk(clk), .reset(reset), .imem_raddr(raddr_d), .imem_rdata(rdata_d),
        .out_valid(valid_d), .out_ready(out_ready), .out_inst(inst_d), .out_pc(pc_d),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
`ifdef FETCH_QUEUE_STATS_EN
        , .stat_fetched(sf_d), .stat_killed(sk_d), .stat_stall(ss_d)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1ns after the last edge that saw reset high.
    task automatic do_reset(input logic rdy);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        out_ready   = rdy;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        out_ready   = 1'b1;
        tick();
        tick();
        n_checks++;
        if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
        n_checks++;
        if (inst_a !== 16'h0000) begin n_fail++; $display("FAIL reset_inst: got %h expected 0000", inst_a); end
        n_checks++;
        if (pc_a !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected 0000", pc_a); end
        n_checks++;
        if (raddr_a !== 15'h0000) begin n_fail++; $display("FAIL reset_raddr: got %h expected 0000", raddr_a); end
        n_checks++;
        if (raddr_w !== 15'h7FFE) begin n_fail++; $display("FAIL reset_raddr_wrap: got %h expected 7ffe", raddr_w); end
`ifdef FETCH_QUEUE_STATS_EN
        n_checks++;
        if ({sf_a, sk_a, ss_a} !== 96'd0) begin n_fail++; $display("FAIL reset_stats: got %h %h %h expected 0", sf_a, sk_a, ss_a); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_stream;
        do_reset(1'b1);
        tick();
        n_checks++;
        if (valid_a !== 1'b0) begin n_fail++; $display("FAIL stream_lat1: got %b expected 0", valid_a); end
        tick();
        n_checks++;
        if (valid_a !== 1'b0) begin n_fail++; $display("FAIL stream_lat2: got %b expected 0", valid_a); end
        tick();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (valid_a !== 1'b1 || pc_a !== 16'(2 * k) || inst_a !== 16'(16'h8000 + k)) begin
                n_fail++;
                $display("FAIL stream_%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                         k, valid_a, pc_a, inst_a, 16'(2 * k), 16'(16'h8000 + k));
            end
            tick();
        end
    endtask

    task automatic test_wrap;
        logic [15:0] epc;
        do_reset(1'b1);
        tick();
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            epc = 16'hFFFC + 16'(2 * k);
            n_checks++;
            if (valid_w !== 1'b1 || pc_w !== epc || inst_w !== (16'h8000 + {1'b0, epc[15:1]})) begin
                n_fail++;
                $display("FAIL wrap_%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                         k, valid_w, pc_w, inst_w, epc, 16'h8000 + {1'b0, epc[15:1]});
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        int seen;
        do_reset(1'b0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c >= 3) begin
                n_checks++;
                if (valid_a !== 1'b1 || inst_a !== 16'h8000 || pc_a !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL hold_%0d: got v=%b pc=%h inst=%h expected v=1 pc=0000 inst=8000",
                             c, valid_a, pc_a, inst_a);
                end
            end
        end
        n_checks++;
        if (raddr_a !== 15'h0004) begin n_fail++; $display("FAIL hold_raddr: got %h expected 0004", raddr_a); end
`ifdef FETCH_QUEUE_STATS_EN
        n_checks++;
        if (ss_a !== 32'd7 || sf_a !== 32'd4) begin
            n_fail++; $display("FAIL hold_stats: got stall=%0d fetched=%0d expected 7 4", ss_a, sf_a);
        end
`endif
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen < 5; c++) begin
            if (valid_a) begin
                n_checks++;
                if (pc_a !== 16'(2 * seen) || inst_a !== 16'(16'h8000 + seen)) begin
                    n_fail++;
                    $display("FAIL drain_%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                             seen, pc_a, inst_a, 16'(2 * seen), 16'(16'h8000 + seen));
                end
                seen++;
            end
            tick();
        end
        n_checks++;
        if (seen != 5) begin n_fail++; $display("FAIL drain_count: got %0d expected 5", seen); end
    endtask

    // DEPTH 8 instance: 3 buffered and 2 in flight at the redirect.
    task automatic test_redirect;
        int low;
        logic [31:0] k0;
        do_reset(1'b0);
        for (int c = 0; c < 5; c++) tick();
`ifdef FETCH_QUEUE_STATS_EN
        k0 = sk_d;
`else
        k0 = 32'd0;
`endif
        redirect    = 1'b1;
        redirect_pc = 16'h0101;
        out_ready   = 1'b1;
        tick();
        redirect = 1'b0;
`ifdef FETCH_QUEUE_STATS_EN
        n_checks++;
        if (sk_d !== k0 + 32'd5) begin n_fail++; $display("FAIL stat_killed: got %0d expected %0d", sk_d, k0 + 32'd5); end
`endif
        low = 0;
        for (int c = 0; c < 10 && !valid_d; c++) begin
            low++;
            tick();
        end
        n_checks++;
        if (low != 3) begin n_fail++; $display("FAIL redir_low: got %0d expected 3", low); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (valid_d !== 1'b1 || pc_d !== 16'(16'h0100 + 2 * k) || inst_d !== 16'(16'h8080 + k)) begin
                n_fail++;
                $display("FAIL redir_%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                         k, valid_d, pc_d, inst_d, 16'(16'h0100 + 2 * k), 16'(16'h8080 + k));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back_redirect;
        int seen;
        do_reset(1'b1);
        for (int c = 0; c < 4; c++) tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect_pc = 16'h0080;
        tick();
        redirect = 1'b0;
        n_checks++;
        if (valid_a !== 1'b0) begin n_fail++; $display("FAIL b2b_valid: got %b expected 0", valid_a); end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (valid_a) begin
                n_checks++;
                if (pc_a !== 16'(16'h0080 + 2 * seen)) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got pc=%h expected %h", seen, pc_a, 16'(16'h0080 + 2 * seen));
                end
                seen++;
            end
            tick();
        end
        n_checks++;
        if (seen != 7) begin n_fail++; $display("FAIL b2b_count: got %0d expected 7", seen); end
    endtask

    task automatic test_halt;
        int seen;
        int c;
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) tick();
        halt = 1'b1;
        tick();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid_a) begin
                n_checks++;
                if (pc_a !== 16'(8 + 2 * seen)) begin
                    n_fail++; $display("FAIL halt_pc_%0d: got %h expected %h", seen, pc_a, 16'(8 + 2 * seen));
                end
                seen++;
            end
            tick();
        end
        n_checks++;
        if (seen != 2) begin n_fail++; $display("FAIL halt_count: got %0d expected 2", seen); end
        n_checks++;
        if (valid_a !== 1'b0 || raddr_a !== 15'h0006) begin
            n_fail++; $display("FAIL halt_idle: got v=%b raddr=%h expected v=0 raddr=0006", valid_a, raddr_a);
        end
        halt = 1'b0;
        c = 0;
        while (!valid_a && c < 10) begin
            tick();
            c++;
        end
        n_checks++;
        if (valid_a !== 1'b1 || pc_a !== 16'h000C) begin
            n_fail++; $display("FAIL halt_resume: got v=%b pc=%h expected v=1 pc=000c", valid_a, pc_a);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_wrap();
        test_backpressure();
        test_redirect();
        test_back_to_back_redirect();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
